// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the memory-mapped UART data register and the UART transmitter
// Ports: clk, rst (async active-low); in_data/in_valid/in_ready write side;
//        out_data/out_valid/out_ready read side; count/full/empty occupancy;
//        overflow sticky flag with clr_overflow synchronous clear.
module uart_tx_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_overflow
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr, r_rd_ptr;
  logic             r_overflow;
  logic             w_push, w_pop;
  // Pointers carry one extra MSB so full and empty are distinguishable when the low bits match.
  assign empty     = r_wr_ptr == r_rd_ptr;
  assign full      = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) && (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign overflow  = r_overflow;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= in_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      // A dropped write sets the flag even if software clears it in the same cycle.
      r_overflow <= (in_valid && !in_ready) ? 1'b1 : clr_overflow ? 1'b0 : r_overflow;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] count;
  logic       full, empty, overflow;
  logic       clr_overflow = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       clr;
    int         cnt;
    logic       ovf;
    logic [7:0] head;
  } vec_t;
  vec_t vt[22];
  uart_tx_fifo #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // Reference: a queue of bytes plus a sticky flag, updated once per rising edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    bit f;
    bit pu;
    bit po;
    in_valid = iv; in_data = d; out_ready = ordy; clr_overflow = clr;
    @(posedge clk);
    f  = q.size() == 8;
    pu = iv && !f;
    po = ordy && q.size() > 0;
    if (po) void'(q.pop_front());
    if (pu) q.push_back(d);
    m_ovf = (iv && f) ? 1'b1 : clr ? 1'b0 : m_ovf;
    #1;
  endtask
  task automatic check_model(input string n);
    chk({n, "_count"}, 32'(count), 32'(q.size()));
    chk({n, "_full"}, 32'(full), 32'(q.size() == 8));
    chk({n, "_empty"}, 32'(empty), 32'(q.size() == 0));
    chk({n, "_in_ready"}, 32'(in_ready), 32'(q.size() != 8));
    chk({n, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({n, "_overflow"}, 32'(overflow), 32'(m_ovf));
    if (q.size() > 0) chk({n, "_out_data"}, 32'(out_data), 32'(q[0]));
  endtask
  initial begin
    int next;
    int got;
    int cyc;
    for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 8'(8'h41 + i), 1'b0, 1'b0, i + 1, 1'b0, 8'h41};
    vt[8]  = '{1'b1, 8'h49, 1'b0, 1'b1, 8, 1'b1, 8'h41};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8, 1'b0, 8'h41};
    vt[10] = '{1'b1, 8'h49, 1'b1, 1'b0, 7, 1'b1, 8'h42};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 7, 1'b0, 8'h42};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 6, 1'b0, 8'h43};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 5, 1'b0, 8'h44};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b0, 8'h45};
    vt[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 8'h46};
    vt[16] = '{1'b1, 8'h55, 1'b1, 1'b0, 3, 1'b0, 8'h47};
    vt[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 8'h48};
    vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h55};
    vt[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vt[21] = '{1'b1, 8'h66, 1'b1, 1'b0, 1, 1'b0, 8'h66};
    #12;
    chk("reset_empty", 32'(empty), 1);
    chk("reset_full", 32'(full), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_overflow", 32'(overflow), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) begin
      step(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].clr);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].cnt == 8));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].cnt == 0));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].cnt != 8));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].cnt != 0));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].ovf));
      if (vt[i].cnt > 0) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].head));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_model("drain");
    next = 0; got = 0; cyc = 0;
    while (got < 40 && cyc < 2000) begin
      logic iv;
      logic ordy;
      iv   = next < 40 && q.size() < 8 && $urandom_range(0, 2) != 0;
      ordy = $urandom_range(0, 2) != 0;
      check_model("stream");
      chk("stream_count_le8", 32'(count <= 4'd8), 1);
      if (ordy && out_valid) begin
        chk("stream_order", 32'(out_data), 32'(got));
        got++;
      end
      step(iv, 8'(next), ordy, 1'b0);
      if (iv) next++;
      cyc++;
    end
    chk("stream_done", 32'(got), 40);
    chk("stream_no_overflow", 32'(overflow), 0);
    for (int i = 0; i < 300; i++) begin
      check_model("rand");
      step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end
    check_model("rand_end");
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    check_model("pre_reset");
    #2 rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    chk("midreset_empty", 32'(empty), 1);
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_count", 32'(count), 0);
    chk("midreset_in_ready", 32'(in_ready), 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check_model("post_reset");
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check_model("post_reset_push");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
